config_spi_flash_loader: RTL

// - Boot-time configuration source: reads the fabric bitstream from an external SPI NOR flash (cmd 0x03 READ).
// - Emits 32-bit words on a WriteData/WriteStrobe pair, same format the UART and bitbang ports deliver.
// - Sits upstream of the config port mux; Active selects it over other ports and resets the config FSM.

---
 rtl/config_spi_flash_loader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/config_spi_flash_loader.sv
// config_spi_flash_loader
// Boot-time configuration source. It issues a SPI NOR READ (0x03) from
// START_ADDR, hunts for SYNC_WORD, then streams 32-bit words out on a
// WriteData/WriteStrobe pair until END_WORD, MAX_WORDS or a failed hunt.
// The SPI link runs in mode 0: SCK idles low, MOSI changes while SCK is low,
// and MISO is captured on the CLK cycle in which SCK rises.
module config_spi_flash_loader #(
  parameter int          CLK_DIV     = 2,
  parameter logic [23:0] START_ADDR  = 24'h000000,
  parameter logic [31:0] SYNC_WORD   = 32'hFAB0FAB1,
  parameter logic [31:0] END_WORD    = 32'hFFFFFFFF,
  parameter int          SYNC_SEARCH = 256,
  parameter int          MAX_WORDS   = 65536,
  parameter bit          AUTO_BOOT   = 1'b1
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        Start,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [31:0] WriteData,
  output logic        WriteStrobe,
  output logic        Active,
  output logic        Done,
  output logic        Error
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EMIT_W = $clog2(MAX_WORDS + 1);
  localparam int HUNT_W = $clog2(SYNC_SEARCH + 1);

  localparam logic [31:0]       CMD_WORD   = {8'h03, START_ADDR};
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [EMIT_W-1:0] EMIT_LIMIT = EMIT_W'(MAX_WORDS);
  localparam logic [HUNT_W-1:0] HUNT_LIMIT = HUNT_W'(SYNC_SEARCH);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    HUNT,
    STREAM,
    DONE,
    ERROR
  } state_t;

  state_t            state;
  logic              bootPending;   // auto-boot launch still owed
  logic [DIV_W-1:0]  divCnt;        // CLK cycles into the current SCK half-period
  logic [4:0]        bitCnt;        // SCK rising edges within the current 32-bit field
  logic [31:0]       cmdShift;      // command/address bits still to be sent
  logic [31:0]       rxShift;       // MISO samples of the word in flight
  logic [31:0]       wordBuf;       // last complete word, waiting to be judged
  logic              wordReady;     // wordBuf was filled on the previous cycle
  logic [EMIT_W-1:0] emitCnt;
  logic [HUNT_W-1:0] huntCnt;

  logic              sckEdge;
  logic              riseNow;
  logic              fallNow;
  logic              spiRunning;
  logic              launch;
  logic              wordIsSync;
  logic              emitNow;
  logic              endLoad;
  logic              failLoad;
  logic [31:0]       rxWord;
  logic [EMIT_W-1:0] emitNext;
  logic [HUNT_W-1:0] huntNext;

  // Decode SCK edges, load launch, and the verdict on a freshly completed word.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch can form.
    launch     = 1'b0;
    spiRunning = 1'b0;
    case (state)
      IDLE:               launch     = Start || bootPending;
      DONE, ERROR:        launch     = Start;
      CMD, HUNT, STREAM:  spiRunning = 1'b1;
      default:            launch     = 1'b0;
    endcase

    sckEdge    = (divCnt == DIV_LAST);
    riseNow    = sckEdge && !spi_sck;
    fallNow    = sckEdge && spi_sck;
    rxWord     = {rxShift[30:0], spi_miso};

    emitNext   = emitCnt + EMIT_W'(1);
    huntNext   = huntCnt + HUNT_W'(1);
    wordIsSync = (wordBuf == SYNC_WORD);

    emitNow  = wordReady && (((state == HUNT) && wordIsSync) ||
                             ((state == STREAM) && (wordBuf != END_WORD)));
    endLoad  = wordReady && (((state == STREAM) && (wordBuf == END_WORD)) ||
                             (emitNow && (emitNext == EMIT_LIMIT)));
    failLoad = wordReady && (state == HUNT) && !wordIsSync && (huntNext == HUNT_LIMIT);
  end

  // Load sequencer: SPI bit engine, word assembly, hunt/stream decisions and outputs.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      bootPending <= AUTO_BOOT;
      divCnt      <= '0;
      bitCnt      <= '0;
      cmdShift    <= '0;
      rxShift     <= '0;
      wordBuf     <= '0;
      wordReady   <= 1'b0;
      emitCnt     <= '0;
      huntCnt     <= '0;
      spi_cs_n    <= 1'b1;
      spi_sck     <= 1'b0;
      spi_mosi    <= 1'b0;
      WriteData   <= '0;
      WriteStrobe <= 1'b0;
      Active      <= 1'b0;
      Done        <= 1'b0;
      Error       <= 1'b0;
    end else begin
      // NOTE: state is updated with <= so every test below sees the pre-edge values.
      WriteStrobe <= 1'b0;

      if (launch) begin
        state       <= CMD;
        bootPending <= 1'b0;
        divCnt      <= '0;
        bitCnt      <= '0;
        cmdShift    <= CMD_WORD;
        rxShift     <= '0;
        wordReady   <= 1'b0;
        emitCnt     <= '0;
        huntCnt     <= '0;
        spi_cs_n    <= 1'b0;
        spi_sck     <= 1'b0;
        spi_mosi    <= CMD_WORD[31];
        Active      <= 1'b1;
        Done        <= 1'b0;
        Error       <= 1'b0;
      end else if (spiRunning) begin
        if (sckEdge) begin
          divCnt  <= '0;
          spi_sck <= ~spi_sck;
        end else begin
          divCnt <= divCnt + DIV_W'(1);
        end

        // MOSI only moves while SCK goes low; zeros follow once the command is out.
        if (fallNow) begin
          cmdShift <= {cmdShift[30:0], 1'b0};
          spi_mosi <= cmdShift[30];
        end

        if (riseNow) begin
          bitCnt <= bitCnt + 5'd1;
          if (state == CMD) begin
            if (bitCnt == 5'd31) begin
              state <= HUNT;
            end
          end else begin
            rxShift <= rxWord;
            if (bitCnt == 5'd31) begin
              wordBuf   <= rxWord;
              wordReady <= 1'b1;
            end
          end
        end

        if (wordReady) begin
          wordReady <= 1'b0;
          if ((state == HUNT) && !wordIsSync) begin
            huntCnt <= huntNext;
          end
        end

        if (emitNow) begin
          WriteData   <= wordBuf;
          WriteStrobe <= 1'b1;
          emitCnt     <= emitNext;
          state       <= STREAM;
        end

        // NOTE: these later assignments win over the SCK/MOSI updates above, so the bus parks on entry.
        if (endLoad || failLoad) begin
          state    <= endLoad ? DONE : ERROR;
          spi_cs_n <= 1'b1;
          spi_sck  <= 1'b0;
          spi_mosi <= 1'b0;
          Active   <= 1'b0;
          Done     <= endLoad;
          Error    <= failLoad;
        end
      end
    end
  end

endmodule
